// File: rtl/mc_controller_pkg.sv
// Shared constants and decode helpers for the multi-cycle MIPS control FSM.
// Holds the opcode and funct encodings, the ALU operation codes, the ALU
// operation classes, the state encoding, the datapath select codes, and a
// per-state control-word decode. Nothing in this file contains state.
package mc_controller_pkg;

  localparam int unsigned StateWidth = 4;

  // Opcodes, instt[31:26]
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  // R-type funct codes, instt[5:0]
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;
  localparam logic [5:0] FunctJr  = 6'b001000;

  // Datapath select codes
  localparam logic [1:0] RegDstRt       = 2'd0;
  localparam logic [1:0] RegDstRd       = 2'd1;
  localparam logic [1:0] RegDstRa       = 2'd2;
  localparam logic [1:0] MemToRegAluOut = 2'd0;
  localparam logic [1:0] MemToRegMdr    = 2'd1;
  localparam logic [1:0] MemToRegPc     = 2'd2;
  localparam logic [1:0] PcSrcAlu       = 2'd0;
  localparam logic [1:0] PcSrcJump      = 2'd1;
  localparam logic [1:0] PcSrcAluOut    = 2'd2;
  localparam logic [1:0] PcSrcA         = 2'd3;
  localparam logic [1:0] SrcbB          = 2'd0;
  localparam logic [1:0] SrcbFour       = 2'd1;
  localparam logic [1:0] SrcbImm        = 2'd2;
  localparam logic [1:0] SrcbImmSh      = 2'd3;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } alu_op_e;

  // What the ALU is being used for in a state; AluClsNone yields code 000.
  typedef enum logic [2:0] {
    AluClsNone   = 3'd0,
    AluClsMem    = 3'd1,
    AluClsBranch = 3'd2,
    AluClsR      = 3'd3,
    AluClsAddi   = 3'd4,
    AluClsSlti   = 3'd5
  } alu_cls_e;

  // Encoding 4'd15 is never entered; the FSM recovers to StFetch from it.
  typedef enum logic [StateWidth-1:0] {
    StReset  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StREx    = 4'd7,
    StRWb    = 4'd8,
    StBeq    = 4'd9,
    StIEx    = 4'd10,
    StIWb    = 4'd11,
    StJump   = 4'd12,
    StJal    = 4'd13,
    StJr     = 4'd14
  } state_e;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       lord;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  // R-type functs that execute through R_EX (jr is handled separately).
  function automatic logic funct_is_alu(logic [5:0] funct);
    return (funct == FunctAdd) || (funct == FunctSub) || (funct == FunctAnd) ||
           (funct == FunctOr)  || (funct == FunctSlt);
  endfunction

  function automatic ctrl_t state_ctrl(state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.alu_srcb = SrcbFour;
        c.pc_src   = PcSrcAlu;
        c.pc_write = 1'b1;
      end
      StDecode: c.alu_srcb = SrcbImmSh;
      StMemAdr: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SrcbImm;
      end
      StMemRd: begin
        c.lord     = 1'b1;
        c.mem_read = 1'b1;
      end
      StMemWb: begin
        c.reg_dst    = RegDstRt;
        c.mem_to_reg = MemToRegMdr;
        c.reg_write  = 1'b1;
      end
      StMemWr: begin
        c.lord      = 1'b1;
        c.mem_write = 1'b1;
      end
      StREx: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SrcbB;
      end
      StRWb: begin
        c.reg_dst    = RegDstRd;
        c.mem_to_reg = MemToRegAluOut;
        c.reg_write  = 1'b1;
      end
      StBeq: begin
        c.alu_srca      = 1'b1;
        c.alu_srcb      = SrcbB;
        c.pc_src        = PcSrcAluOut;
        c.pc_write_cond = 1'b1;
      end
      StIEx: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SrcbImm;
      end
      StIWb: begin
        c.reg_dst    = RegDstRt;
        c.mem_to_reg = MemToRegAluOut;
        c.reg_write  = 1'b1;
      end
      StJump: begin
        c.pc_src   = PcSrcJump;
        c.pc_write = 1'b1;
      end
      StJal: begin
        c.reg_dst    = RegDstRa;
        c.mem_to_reg = MemToRegPc;
        c.reg_write  = 1'b1;
        c.pc_src     = PcSrcJump;
        c.pc_write   = 1'b1;
      end
      StJr: begin
        c.pc_src   = PcSrcA;
        c.pc_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic alu_cls_e state_alu_cls(state_e st, logic [5:0] op);
    alu_cls_e cls;
    cls = AluClsNone;
    case (st)
      StFetch, StDecode, StMemAdr: cls = AluClsMem;
      StREx:                       cls = AluClsR;
      StBeq:                       cls = AluClsBranch;
      StIEx:                       cls = (op == OpSlti) ? AluClsSlti : AluClsAddi;
      default:                     cls = AluClsNone;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_controller_alu_ctrl_dec.sv
// ALU control decoder.
// Maps the ALU usage class of a state plus the R-type funct field to the
// 3-bit ALU operation code.
//   alu_cls_i : how the ALU is being used (address add, branch compare, R, addi, slti)
//   funct_i   : instt[5:0], only consulted for the R class
//   alu_op_o  : ALU operation code
module mc_controller_alu_ctrl_dec
  import mc_controller_pkg::*;
(
  input  alu_cls_e   alu_cls_i,
  input  logic [5:0] funct_i,
  output alu_op_e    alu_op_o
);

  always_comb begin
    alu_op_o = AluAnd;
    case (alu_cls_i)
      AluClsMem, AluClsAddi: alu_op_o = AluAdd;
      AluClsBranch:          alu_op_o = AluSub;
      AluClsSlti:            alu_op_o = AluSlt;
      AluClsR: begin
        case (funct_i)
          FunctAdd: alu_op_o = AluAdd;
          FunctSub: alu_op_o = AluSub;
          FunctAnd: alu_op_o = AluAnd;
          FunctOr:  alu_op_o = AluOr;
          FunctSlt: alu_op_o = AluSlt;
          default:  alu_op_o = AluAnd;
        endcase
      end
      default: alu_op_o = AluAnd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM.
// Sits beside the datapath, reads the latched instruction and the ALU zero
// flag, and drives every mux select, register enable and memory strobe.
// Control outputs are registered: each edge loads the control word of the
// state being entered. PCsig (zero-gated in BEQ) and illegal_op (DECODE only)
// are the two combinational outputs.
//   clk, rst    : clock, asynchronous active-low reset
//   instt       : IR contents (op = [31:26], funct = [5:0])
//   zero        : ALU zero flag, same cycle
//   reg_dst, mem_to_reg, pc_src, alu_srca, alu_srcb, alu_ctrl : datapath selects
//   reg_write, PCsig, IRwrite, lord, mem_read, mem_write       : enables/strobes
//   illegal_op  : pulse in DECODE for an unknown opcode or R-type funct
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned STATE_W = StateWidth,
  parameter int unsigned ALU_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instt,
  input  logic             zero,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       pc_src,
  output logic             alu_srca,
  output logic [1:0]       alu_srcb,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             reg_write,
  output logic             PCsig,
  output logic             lord,
  output logic             IRwrite,
  output logic             mem_read,
  output logic             mem_write,
  output logic             illegal_op
);

  logic [STATE_W-1:0] state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  alu_op_e            alu_op_d;
  logic [2:0]         alu_op_q;
  logic               decode_illegal;

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instt;

  assign op           = instt[31:26];
  assign funct        = instt[5:0];
  assign unused_instt = ^instt[25:6];

  // Next-state logic; the DECODE branch also flags unknown instructions.
  always_comb begin
    state_d        = STATE_W'(StFetch);
    decode_illegal = 1'b0;
    case (state_e'(state_q))
      StReset: state_d = STATE_W'(StFetch);
      StFetch: state_d = STATE_W'(StDecode);
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = STATE_W'(StMemAdr);
          OpRtype: begin
            if (funct == FunctJr) begin
              state_d = STATE_W'(StJr);
            end else if (funct_is_alu(funct)) begin
              state_d = STATE_W'(StREx);
            end else begin
              decode_illegal = 1'b1;
              state_d        = STATE_W'(StFetch);
            end
          end
          OpBeq:          state_d = STATE_W'(StBeq);
          OpAddi, OpSlti: state_d = STATE_W'(StIEx);
          OpJ:            state_d = STATE_W'(StJump);
          OpJal:          state_d = STATE_W'(StJal);
          default: begin
            decode_illegal = 1'b1;
            state_d        = STATE_W'(StFetch);
          end
        endcase
      end
      StMemAdr: state_d = (op == OpSw) ? STATE_W'(StMemWr) : STATE_W'(StMemRd);
      StMemRd:  state_d = STATE_W'(StMemWb);
      StREx:    state_d = STATE_W'(StRWb);
      StIEx:    state_d = STATE_W'(StIWb);
      // Writeback, BEQ, jumps and any unused encoding all return to FETCH.
      default:  state_d = STATE_W'(StFetch);
    endcase
  end

  // Control word of the state being entered, registered alongside the state.
  always_comb begin
    ctrl_d = state_ctrl(state_e'(state_d));
  end

  mc_controller_alu_ctrl_dec u_alu_ctrl_dec (
    .alu_cls_i (state_alu_cls(state_e'(state_d), op)),
    .funct_i   (funct),
    .alu_op_o  (alu_op_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= STATE_W'(StReset);
      ctrl_q   <= '0;
      alu_op_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign pc_src     = ctrl_q.pc_src;
  assign alu_srca   = ctrl_q.alu_srca;
  assign alu_srcb   = ctrl_q.alu_srcb;
  assign alu_ctrl   = ALU_W'(alu_op_q);
  assign reg_write  = ctrl_q.reg_write;
  assign PCsig      = ctrl_q.pc_write | (ctrl_q.pc_write_cond & zero);
  assign lord       = ctrl_q.lord;
  assign IRwrite    = ctrl_q.ir_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign illegal_op = decode_illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller. Outputs are packed into one vector and
// compared against hand-built per-state constants on the falling clock edge.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instt = 32'h0;
  logic        zero = 1'b0;

  logic [1:0] reg_dst, mem_to_reg, pc_src, alu_srcb;
  logic       alu_srca, reg_write, PCsig, lord, IRwrite, mem_read, mem_write, illegal_op;
  logic [2:0] alu_ctrl;
  logic [18:0] outs;

  int total = 0;
  int bad   = 0;

  mc_controller #(
    .STATE_W (4),
    .ALU_W   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instt      (instt),
    .zero       (zero),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .reg_write  (reg_write),
    .PCsig      (PCsig),
    .lord       (lord),
    .IRwrite    (IRwrite),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // {reg_dst, mem_to_reg, pc_src, srca, srcb, alu_ctrl,
  //  reg_write, PCsig, lord, IRwrite, mem_read, mem_write, illegal_op}
  assign outs = {reg_dst, mem_to_reg, pc_src, alu_srca, alu_srcb, alu_ctrl,
                 reg_write, PCsig, lord, IRwrite, mem_read, mem_write, illegal_op};

  localparam logic [18:0] E_ZERO     = 19'd0;
  localparam logic [18:0] E_FETCH    = {2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 3'b010, 7'b0101100};
  localparam logic [18:0] E_DECODE   = {2'd0, 2'd0, 2'd0, 1'b0, 2'd3, 3'b010, 7'b0000000};
  localparam logic [18:0] E_ILL      = {2'd0, 2'd0, 2'd0, 1'b0, 2'd3, 3'b010, 7'b0000001};
  localparam logic [18:0] E_MEM_ADR  = {2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 3'b010, 7'b0000000};
  localparam logic [18:0] E_MEM_RD   = {2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 3'b000, 7'b0010100};
  localparam logic [18:0] E_MEM_WB   = {2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 3'b000, 7'b1000000};
  localparam logic [18:0] E_MEM_WR   = {2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 3'b000, 7'b0010010};
  localparam logic [18:0] E_REX_SLT  = {2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 3'b111, 7'b0000000};
  localparam logic [18:0] E_REX_SUB  = {2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 3'b110, 7'b0000000};
  localparam logic [18:0] E_REX_OR   = {2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 3'b001, 7'b0000000};
  localparam logic [18:0] E_R_WB     = {2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 3'b000, 7'b1000000};
  localparam logic [18:0] E_BEQ_T    = {2'd0, 2'd0, 2'd2, 1'b1, 2'd0, 3'b110, 7'b0100000};
  localparam logic [18:0] E_BEQ_N    = {2'd0, 2'd0, 2'd2, 1'b1, 2'd0, 3'b110, 7'b0000000};
  localparam logic [18:0] E_IEX_ADD  = {2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 3'b010, 7'b0000000};
  localparam logic [18:0] E_IEX_SLT  = {2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 3'b111, 7'b0000000};
  localparam logic [18:0] E_I_WB     = {2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 3'b000, 7'b1000000};
  localparam logic [18:0] E_JUMP     = {2'd0, 2'd0, 2'd1, 1'b0, 2'd0, 3'b000, 7'b0100000};
  localparam logic [18:0] E_JAL      = {2'd2, 2'd2, 2'd1, 1'b0, 2'd0, 3'b000, 7'b1100000};
  localparam logic [18:0] E_JR       = {2'd0, 2'd0, 2'd3, 1'b0, 2'd0, 3'b000, 7'b0100000};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (outs !== E_ZERO) begin
        bad++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, outs, E_ZERO);
      end
    end
    rst = 1'b1;
    step();
    total++;
    if (outs !== E_FETCH) begin
      bad++;
      $display("FAIL reset_fetch got=%h exp=%h", outs, E_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [18:0] exp [5];
    exp = '{E_DECODE, E_MEM_ADR, E_MEM_RD, E_MEM_WB, E_FETCH};
    instt = 32'h8C220004;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (outs !== exp[i]) begin
        bad++;
        $display("FAIL lw[%0d] got=%h exp=%h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [18:0] exp [4];
    exp = '{E_DECODE, E_MEM_ADR, E_MEM_WR, E_FETCH};
    instt = 32'hAC220004;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (outs !== exp[i]) begin
        bad++;
        $display("FAIL sw[%0d] got=%h exp=%h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [18:0] exp_t [3];
    logic [18:0] exp_n [3];
    exp_t = '{E_DECODE, E_BEQ_T, E_FETCH};
    exp_n = '{E_DECODE, E_BEQ_N, E_FETCH};
    instt = 32'h10220003;
    zero  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (outs !== exp_t[i]) begin
        bad++;
        $display("FAIL beq_taken[%0d] got=%h exp=%h", i, outs, exp_t[i]);
      end
    end
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (outs !== exp_n[i]) begin
        bad++;
        $display("FAIL beq_not[%0d] got=%h exp=%h", i, outs, exp_n[i]);
      end
      // PCsig in BEQ follows zero within the cycle
      if (i == 1) begin
        zero = 1'b1;
        #1;
        total++;
        if (PCsig !== 1'b1) begin
          bad++;
          $display("FAIL beq_zero_live got=%b exp=1", PCsig);
        end
        zero = 1'b0;
      end
    end
  endtask

  task automatic test_jal();
    logic [18:0] exp [3];
    exp = '{E_DECODE, E_JAL, E_FETCH};
    instt = 32'h0C000010;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (outs !== exp[i]) begin
        bad++;
        $display("FAIL jal[%0d] got=%h exp=%h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [18:0] exp [3];
    exp = '{E_DECODE, E_JUMP, E_FETCH};
    instt = 32'h08000010;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (outs !== exp[i]) begin
        bad++;
        $display("FAIL j[%0d] got=%h exp=%h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_jr();
    logic [18:0] exp [3];
    exp = '{E_DECODE, E_JR, E_FETCH};
    instt = 32'h03E00008;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (outs !== exp[i]) begin
        bad++;
        $display("FAIL jr[%0d] got=%h exp=%h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [31:0] ins [3];
    logic [18:0] ex  [3];
    ins = '{32'h0022182A, 32'h00221822, 32'h00221825};
    ex  = '{E_REX_SLT, E_REX_SUB, E_REX_OR};
    for (int k = 0; k < 3; k++) begin
      logic [18:0] exp [4];
      exp = '{E_DECODE, ex[k], E_R_WB, E_FETCH};
      instt = ins[k];
      for (int i = 0; i < 4; i++) begin
        step();
        total++;
        if (outs !== exp[i]) begin
          bad++;
          $display("FAIL rtype%0d[%0d] got=%h exp=%h", k, i, outs, exp[i]);
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [31:0] ins [2];
    logic [18:0] ex  [2];
    ins = '{32'h20210005, 32'h28210005};
    ex  = '{E_IEX_ADD, E_IEX_SLT};
    for (int k = 0; k < 2; k++) begin
      logic [18:0] exp [4];
      exp = '{E_DECODE, ex[k], E_I_WB, E_FETCH};
      instt = ins[k];
      for (int i = 0; i < 4; i++) begin
        step();
        total++;
        if (outs !== exp[i]) begin
          bad++;
          $display("FAIL itype%0d[%0d] got=%h exp=%h", k, i, outs, exp[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    logic [18:0] exp [2];
    ins = '{32'hFC000000, 32'h0000003F};
    exp = '{E_ILL, E_FETCH};
    for (int k = 0; k < 2; k++) begin
      instt = ins[k];
      for (int i = 0; i < 2; i++) begin
        step();
        total++;
        if (outs !== exp[i]) begin
          bad++;
          $display("FAIL illegal%0d[%0d] got=%h exp=%h", k, i, outs, exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    instt = 32'hAC220004;
    step();
    step();
    step();
    total++;
    if (mem_write !== 1'b1) begin
      bad++;
      $display("FAIL midwr_pre got=%b exp=1", mem_write);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (outs !== E_ZERO) begin
      bad++;
      $display("FAIL midwr_async got=%h exp=%h", outs, E_ZERO);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    total++;
    if (outs !== E_FETCH) begin
      bad++;
      $display("FAIL midwr_refetch got=%h exp=%h", outs, E_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_jump();
    test_jr();
    test_rtype();
    test_itype();
    test_illegal();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
